// File: rtl/shift_unit_pkg.sv
// Shared definitions for the shift unit: datapath widths, opcode encoding
// and the word-result sign-extension helper.
package shift_unit_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = 6;
  localparam int RD_W    = 5;
  localparam int OP_W    = 2;
  localparam int CNT_W   = 16;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } shift_op_e;

  // W-variant results are always the low 32 bits sign-extended to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Upstream request and downstream result handshakes of the shift unit.
// The master side issues operations and consumes results; the slave side
// is the shift unit itself.
interface shift_unit_if;
  import shift_unit_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic               in_word;
  logic               in_use_imm;
  logic [XLEN-1:0]    in_rs1;
  logic [XLEN-1:0]    in_rs2;
  logic [SHAMT_W-1:0] in_imm;
  logic [RD_W-1:0]    in_rd;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_data;
  logic [RD_W-1:0]    out_rd;
  logic               out_illegal;

  modport master (
    output in_valid, in_op, in_word, in_use_imm, in_rs1, in_rs2, in_imm, in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_word, in_use_imm, in_rs1, in_rs2, in_imm, in_rd,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_rd, out_illegal
  );

endinterface

// File: rtl/shift_unit_shifter.sv
// Purely combinational 64-bit barrel shifter. Any mode other than the three
// shift encodings passes the operand through unchanged.
module shift_unit_shifter
  import shift_unit_pkg::*;
(
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_e          mode,
  output logic [XLEN-1:0]    dout
);

  // Select the shift direction and fill according to the mode.
  always_comb begin
    dout = din;
    case (mode)
      OP_SLL:  dout = din << shamt;
      OP_SRL:  dout = din >> shamt;
      OP_SRA:  dout = $signed(din) >>> shamt;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Two-stage valid/ready shift pipeline. Stage 1 captures prepared operands
// (shift amount and word-adjusted source), stage 2 captures the shifter
// result. A flush kills both stages; op_count tallies delivered results.
module shift_unit
  import shift_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic [CNT_W-1:0] op_count,
  shift_unit_if.slave      bus
);

  shift_op_e          in_op;
  logic [SHAMT_W-1:0] prep_shamt;
  logic [XLEN-1:0]    prep_din;

  logic               s1_valid;
  logic [XLEN-1:0]    s1_din;
  logic [SHAMT_W-1:0] s1_shamt;
  shift_op_e          s1_op;
  logic               s1_word;
  logic [RD_W-1:0]    s1_rd;

  logic               s2_valid;
  logic [XLEN-1:0]    s2_data;
  logic [RD_W-1:0]    s2_rd;
  logic               s2_illegal;

  logic               s1_load;
  logic               s2_load;
  logic               accept;
  logic               out_fire;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    s2_result;

  // Only the low bits of rs2 can form a shift amount.
  logic [XLEN-SHAMT_W-1:0] unused_rs2;
  assign unused_rs2 = bus.in_rs2[XLEN-1:SHAMT_W];

  assign in_op    = shift_op_e'(bus.in_op);
  assign out_fire = s2_valid && bus.out_ready;
  assign s2_load  = !s2_valid || bus.out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign accept   = bus.in_valid && s1_load && !flush;

  assign bus.in_ready    = s1_load && !flush;
  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = s2_data;
  assign bus.out_rd      = s2_rd;
  assign bus.out_illegal = s2_illegal;

  // Operand preparation: word ops use a 5-bit amount and a 32-bit source.
  always_comb begin
    prep_shamt = bus.in_use_imm ? bus.in_imm : bus.in_rs2[SHAMT_W-1:0];
    prep_din   = bus.in_rs1;
    if (bus.in_word) begin
      prep_shamt[SHAMT_W-1] = 1'b0;
      if (in_op == OP_SRA) begin
        prep_din = sext32(bus.in_rs1[31:0]);
      end else if (in_op == OP_SRL) begin
        prep_din = {{(XLEN-32){1'b0}}, bus.in_rs1[31:0]};
      end
    end
  end

  // Stage 1 occupancy; flush wins over any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
    end
  end

  // Stage 1 operand registers only change on an accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_din   <= prep_din;
      s1_shamt <= prep_shamt;
      s1_op    <= in_op;
      s1_word  <= bus.in_word;
      s1_rd    <= bus.in_rd;
    end
  end

  shift_unit_shifter u_shifter (
    .din   (s1_din),
    .shamt (s1_shamt),
    .mode  (s1_op),
    .dout  (shifted)
  );

  // Result shaping: word results are re-sign-extended, illegal ops read zero.
  always_comb begin
    s2_result = shifted;
    if (s1_word) begin
      s2_result = sext32(shifted[31:0]);
    end
    if (s1_op == OP_ILL) begin
      s2_result = '0;
    end
  end

  // Stage 2 result register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data    <= s2_result;
        s2_rd      <= s1_rd;
        s2_illegal <= (s1_op == OP_ILL);
      end
    end
  end

  // Delivered-result counter; a transfer coinciding with a flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed corner cases plus a random
// stream scored against a behavioural model of the shift rules.
module tb_shift_unit;

  typedef struct packed {
    logic [1:0]  op;
    logic        word;
    logic        use_imm;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [5:0]  imm;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] op_count;

  shift_unit_if bus_if ();

  shift_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .op_count (op_count),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  logic [15:0] model_count = 16'h0000;
  exp_t        exp_q[$];
  op_t         cur_op;
  bit          last_accept;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Shift rules written directly in terms of the architectural results.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    logic [5:0]  sh;
    logic [31:0] w;
    sh     = o.use_imm ? o.imm : o.rs2[5:0];
    e.rd   = o.rd;
    e.ill  = (o.op == 2'b11);
    e.data = '0;
    w      = '0;
    if (!o.word) begin
      case (o.op)
        2'b00:   e.data = o.rs1 << sh;
        2'b01:   e.data = o.rs1 >> sh;
        2'b10:   e.data = $signed(o.rs1) >>> sh;
        default: e.data = '0;
      endcase
    end else begin
      case (o.op)
        2'b00:   w = o.rs1[31:0] << sh[4:0];
        2'b01:   w = o.rs1[31:0] >> sh[4:0];
        2'b10:   w = $signed(o.rs1[31:0]) >>> sh[4:0];
        default: w = '0;
      endcase
      e.data = (o.op == 2'b11) ? 64'h0 : {{32{w[31]}}, w};
    end
    return e;
  endfunction

  function automatic op_t rand_op(input bit allow_ill);
    op_t o;
    o.op      = allow_ill ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    o.word    = 1'($urandom_range(0, 1));
    o.use_imm = 1'($urandom_range(0, 1));
    o.rs1     = {$urandom, $urandom};
    o.rs2     = {$urandom, $urandom};
    o.imm     = 6'($urandom);
    o.rd      = 5'($urandom);
    case ($urandom_range(0, 7))
      0: o.imm = 6'd0;
      1: o.imm = 6'd63;
      2: o.imm = 6'd31;
      3: o.imm = 6'd32;
      default: ;
    endcase
    return o;
  endfunction

  task automatic drive(input op_t o);
    cur_op               = o;
    bus_if.in_op         = o.op;
    bus_if.in_word       = o.word;
    bus_if.in_use_imm    = o.use_imm;
    bus_if.in_rs1        = o.rs1;
    bus_if.in_rs2        = o.rs2;
    bus_if.in_imm        = o.imm;
    bus_if.in_rd         = o.rd;
  endtask

  function automatic op_t mk(input logic [1:0] op, input logic word, input logic use_imm,
                             input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic [5:0] imm, input logic [4:0] rd);
    op_t o;
    o.op = op; o.word = word; o.use_imm = use_imm;
    o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.rd = rd;
    return o;
  endfunction

  // One clock: sample handshakes mid-cycle, update the scoreboard, then
  // return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_accept = rst_n && bus_if.in_valid && bus_if.in_ready;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      model_count = model_count + 16'd1;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_data", bus_if.out_data, e.data);
        checkOutput("sb_rd", 64'(bus_if.out_rd), 64'(e.rd));
        checkOutput("sb_illegal", 64'(bus_if.out_illegal), 64'(e.ill));
      end
    end
    if (!rst_n || flush) begin
      exp_q.delete();
    end else if (last_accept) begin
      exp_q.push_back(model(cur_op));
    end
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until it is accepted (bounded).
  task automatic applyStimulus(input op_t o);
    bit done = 1'b0;
    drive(o);
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = last_accept;
    end
    bus_if.in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  // After an accept with out_ready high: nothing after one edge, result after two.
  task automatic expect_single(input string tag, input logic [63:0] want_data,
                               input logic [4:0] want_rd, input logic want_ill);
    checkOutput({tag, "_early_valid"}, 64'(bus_if.out_valid), 64'd0);
    tick();
    checkOutput({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
    checkOutput({tag, "_data"}, bus_if.out_data, want_data);
    checkOutput({tag, "_rd"}, 64'(bus_if.out_rd), 64'(want_rd));
    checkOutput({tag, "_illegal"}, 64'(bus_if.out_illegal), 64'(want_ill));
    tick();
    checkOutput({tag, "_count"}, 64'(op_count), 64'(model_count));
  endtask

  // With out_ready low, issue two ops so both stages end up full.
  task automatic fill_two();
    int n = 0;
    drive(rand_op(1'b1));
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (last_accept) begin
        n++;
        drive(rand_op(1'b1));
      end
    end
    bus_if.in_valid = 1'b0;
    checkOutput("fill_two_accepted", 64'(n), 64'd2);
  endtask

  // Watchdog so a wedged handshake can never hang the run.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    op_t         bp_ops[4];
    int          idx;
    bit          done;
    logic [15:0] start_count;

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    drive(mk(2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 6'h0, 5'h0));

    // Reset values while rst_n is held low.
    #3;
    checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("rst_out_data", bus_if.out_data, 64'd0);
    checkOutput("rst_out_rd", 64'(bus_if.out_rd), 64'd0);
    checkOutput("rst_out_illegal", 64'(bus_if.out_illegal), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    checkOutput("post_rst_out_valid", 64'(bus_if.out_valid), 64'd0);

    // Directed single ops with exact expected values.
    applyStimulus(mk(2'b00, 1'b0, 1'b1, 64'h1, 64'h0, 6'd63, 5'd3));
    expect_single("sll64_63", 64'h8000_0000_0000_0000, 5'd3, 1'b0);
    applyStimulus(mk(2'b10, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd4, 6'd0, 5'd9));
    expect_single("sraw_4", 64'hFFFF_FFFF_F800_0000, 5'd9, 1'b0);
    applyStimulus(mk(2'b01, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd4, 6'd0, 5'd10));
    expect_single("srlw_4", 64'h0000_0000_0800_0000, 5'd10, 1'b0);
    applyStimulus(mk(2'b11, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd5, 6'd0, 5'd7));
    expect_single("illegal", 64'h0, 5'd7, 1'b1);
    applyStimulus(mk(2'b00, 1'b1, 1'b1, 64'h1234_5678_8000_0001, 64'd0, 6'd0, 5'd1));
    expect_single("sllw_zero", 64'hFFFF_FFFF_8000_0001, 5'd1, 1'b0);
    applyStimulus(mk(2'b10, 1'b0, 1'b1, 64'h8123_4567_89AB_CDEF, 64'd0, 6'd0, 5'd2));
    expect_single("sra64_zero", 64'h8123_4567_89AB_CDEF, 5'd2, 1'b0);
    applyStimulus(mk(2'b01, 1'b1, 1'b1, 64'hDEAD_BEEF_8000_00F0, 64'd0, 6'd36, 5'd4));
    expect_single("srlw_imm36", 64'h0000_0000_0800_000F, 5'd4, 1'b0);
    applyStimulus(mk(2'b00, 1'b1, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFDF, 6'd0, 5'd5));
    expect_single("sllw_31", 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b0);

    // Backpressure: four back-to-back ops against a stalled consumer.
    for (int k = 0; k < 4; k++) bp_ops[k] = rand_op(1'b0);
    bus_if.out_ready = 1'b0;
    idx = 0;
    drive(bp_ops[0]);
    bus_if.in_valid = 1'b1;
    repeat (2) begin
      tick();
      if (last_accept) begin
        idx++;
        if (idx < 4) drive(bp_ops[idx]);
      end
    end
    checkOutput("bp_two_accepted", 64'(idx), 64'd2);
    start_count = model_count;
    repeat (5) begin
      checkOutput("bp_in_ready_low", 64'(bus_if.in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(bus_if.out_valid), 64'd1);
      if (exp_q.size() > 0) begin
        checkOutput("bp_hold_data", bus_if.out_data, exp_q[0].data);
        checkOutput("bp_hold_rd", 64'(bus_if.out_rd), 64'(exp_q[0].rd));
      end
      tick();
      if (last_accept) begin
        idx++;
        if (idx < 4) drive(bp_ops[idx]);
      end
    end
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 20 && (idx < 4 || exp_q.size() > 0); i++) begin
      tick();
      if (last_accept) begin
        idx++;
        if (idx < 4) drive(bp_ops[idx]);
        else bus_if.in_valid = 1'b0;
      end
    end
    bus_if.in_valid = 1'b0;
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    checkOutput("bp_all_delivered", 64'(exp_q.size()), 64'd0);
    checkOutput("bp_op_count", 64'(op_count), 64'(start_count + 16'd4));

    // Flush with both stages full and the consumer stalled.
    bus_if.out_ready = 1'b0;
    fill_two();
    checkOutput("flush_pre_valid", 64'(bus_if.out_valid), 64'd1);
    start_count = model_count;
    flush = 1'b1;
    drive(rand_op(1'b0));
    bus_if.in_valid = 1'b1;
    #1;
    checkOutput("flush_blocks_accept", 64'(bus_if.in_ready), 64'd0);
    tick();
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("flush_op_count", 64'(op_count), 64'(start_count));
    bus_if.out_ready = 1'b1;
    repeat (4) begin
      tick();
      checkOutput("flush_no_stale", 64'(bus_if.out_valid), 64'd0);
    end

    // A transfer in the flush cycle is still counted.
    applyStimulus(rand_op(1'b1));
    tick();
    checkOutput("flush_xfer_pre_valid", 64'(bus_if.out_valid), 64'd1);
    start_count = model_count;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_xfer_count", 64'(op_count), 64'(start_count + 16'd1));
    checkOutput("flush_xfer_valid", 64'(bus_if.out_valid), 64'd0);

    // Random stream with random consumer stalls and idle cycles.
    for (int n = 0; n < 60; n++) begin
      drive(rand_op(1'b1));
      bus_if.in_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
        bus_if.out_ready = ($urandom_range(0, 3) != 0);
        tick();
        done = last_accept;
      end
      checkOutput("rand_accept", 64'(done), 64'd1);
      bus_if.in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        bus_if.out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("rand_op_count", 64'(op_count), 64'(model_count));

    // Asynchronous reset between edges with ops in flight.
    bus_if.out_ready = 1'b0;
    fill_two();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("async_rst_op_count", 64'(op_count), 64'd0);
    checkOutput("async_rst_out_data", bus_if.out_data, 64'd0);
    checkOutput("async_rst_out_illegal", 64'(bus_if.out_illegal), 64'd0);
    exp_q.delete();
    model_count = 16'h0000;
    #2 rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("async_rst_discard", 64'(bus_if.out_valid), 64'd0);
    end

    // Drive the counter to 0xFFFF, then one more transfer must wrap it.
    drive(rand_op(1'b1));
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 70000 && model_count != 16'hFFFF; i++) tick();
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    checkOutput("wrap_at_max", 64'(op_count), 64'h0000_0000_0000_FFFF);
    bus_if.out_ready = 1'b1;
    tick();
    checkOutput("wrap_to_zero", 64'(op_count), 64'h0);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    checkOutput("wrap_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] done, %0d comparisons flagged", failed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL provide ports: clk input 1 (single clock, rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL provide upstream ports: in_valid input 1; in_ready output 1; in_op input 2 (00=SLL, 01=SRL, 10=SRA, 11=illegal); in_word input 1 (32-bit W-variant); in_use_imm input 1; in_rs1 input 64; in_rs2 input 64; in_imm input 6; in_rd input 5.
REQ-003 SHALL provide downstream ports: out_valid output 1; out_ready input 1; out_data output 64; out_rd output 5; out_illegal output 1.
REQ-004 SHALL provide control/status ports: flush input 1 (synchronous pipeline kill); op_count output 16 (completed-op counter).

Function
REQ-005 SHALL be a 2-stage valid/ready pipeline: S1 = operand prepare register, S2 = shift result register; latency from accepted input to out_valid = 2 cycles when not stalled.
REQ-006 SHALL accept input on a cycle with in_valid=1 and in_ready=1; output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-007 S2 SHALL load when S2 empty or output transfer this cycle; S1 SHALL load when S1 empty or S1 moves to S2 this cycle.
REQ-008 in_ready SHALL equal (!s1_valid || s2_load) && !flush, combinational; throughput 1 op/cycle with out_ready held high.
REQ-009 S1 shamt SHALL be in_imm when in_use_imm=1, else in_rs2[5:0]; when in_word=1 shamt[5] SHALL be forced to 0.
REQ-010 S1 din SHALL be: in_word=0 -> in_rs1; in_word=1 with SRA -> sign-extended in_rs1[31:0]; in_word=1 with SRL -> zero-extended in_rs1[31:0]; in_word=1 with SLL -> in_rs1.
REQ-011 S2 result SHALL be shifter output for 64-bit ops; for in_word=1 SHALL be shifter output bits [31:0] sign-extended to 64.
REQ-012 in_op=11 SHALL pass through the pipeline with out_data=0 and out_illegal=1; otherwise out_illegal=0.
REQ-013 out_rd SHALL carry in_rd of the same op, aligned with out_data.
REQ-014 out_data/out_rd/out_illegal SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 flush=1 SHALL clear s1_valid and s2_valid at the next edge, SHALL block acceptance that cycle, and SHALL take priority over any transfer; an output transfer in the flush cycle is still counted.
REQ-016 op_count SHALL increment by 1 on each output transfer, wrapping 0xFFFF->0x0000; illegal ops are counted.
REQ-017 shamt=0 SHALL return din unchanged (word ops still sign-extend bit 31).

Reset
REQ-018 rst_n=0 SHALL asynchronously clear s1_valid, s2_valid, out_valid=0, out_data=0, out_rd=0, out_illegal=0, op_count=0.
REQ-019 in_ready SHALL be 1 from the first edge after reset release (S1 empty); reset mid-operation SHALL discard all in-flight ops without output.
REQ-020 Data-path registers other than those in REQ-018 need no reset.

Structure
REQ-021 Opcode encodings (SLL/SRL/SRA/ILL) and width constants (XLEN=64, SHAMT_W=6) SHALL live in the shared CPU package.
REQ-022 The existing 64-bit combinational shifter SHALL be instantiated once as the sole sub-module, fed from S1 registers; mode = in_op for legal ops.

Verification
REQ-023 SLL 64: rs1=0x1, imm=63, use_imm=1, out_ready=1 -> out_data=0x8000000000000000 two cycles after accept.
REQ-024 SRA word: rs1=0x0000000080000000, rs2=4, word=1 -> out_data=0xFFFFFFFFF8000000; SRL word same inputs -> 0x0000000008000000.
REQ-025 Backpressure: 4 back-to-back ops, out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, outputs held stable, all 4 delivered in order, op_count=4.
REQ-026 Illegal: in_op=11, rd=7 -> out_illegal=1, out_data=0, out_rd=7, op_count increments.
REQ-027 Flush with both stages full and out_ready=0 -> out_valid=0 next cycle, no stale output afterwards, op_count unchanged.
REQ-028 Async reset asserted mid-stream between edges -> out_valid and op_count read 0 immediately; op_count wrap from 0xFFFF -> 0x0000 on next transfer.
